// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator: state encoding, default widths
// and the run-length helper.
package mac_pkg;

   localparam int DATA_SIZE_DEF = 8;
   localparam int ACC_SIZE_DEF  = 21;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } mac_state_t;

   // A requested length of zero runs as a single-sample accumulation.
   function automatic logic [7:0] eff_len(input logic [7:0] len);
      return (len == 8'd0) ? 8'd1 : len;
   endfunction

endpackage

// File: rtl/mac_acc_adder.sv
// Unsigned accumulate step with carry detect; clamps to all-ones when
// MAC_ACCUMULATOR_SAT_EN is defined, otherwise wraps modulo 2^accSize.
module mac_acc_adder #(
   parameter int inSize  = 17,
   parameter int accSize = 21
)(
   input  logic [accSize-1:0] acc,
   input  logic [inSize-1:0]  addend,
`ifdef MAC_ACCUMULATOR_SAT_EN
   input  logic               sat_hold,
`endif
   output logic [accSize-1:0] result,
   output logic               carry
);

   logic [accSize:0] wide;

   always_comb begin
      wide  = {1'b0, acc} + (accSize+1)'(addend);
      carry = wide[accSize];
`ifdef MAC_ACCUMULATOR_SAT_EN
      // Once saturated, stay pinned for the remainder of the run.
      if (sat_hold || carry) begin
         result = '1;
      end else begin
         result = wide[accSize-1:0];
      end
`else
      result = wide[accSize-1:0];
`endif
   end

endmodule

// File: rtl/mac_accumulator.sv
// Streaming accumulator over len samples with valid/ready handshakes on both
// sides. Optional saturation via MAC_ACCUMULATOR_SAT_EN (default: wrap).
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int dataSize = DATA_SIZE_DEF,
   parameter int accSize  = ACC_SIZE_DEF
)(
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [2*dataSize:0]   in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            len,
   input  logic                  clear,
   output logic [accSize-1:0]    sum,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  ovf
);

   localparam int inSize = 2*dataSize + 1;

   mac_state_t          state_reg;
   logic [accSize-1:0]  acc_reg;
   logic [7:0]          count_reg;
   logic [7:0]          len_reg;
   logic                out_valid_reg;
   logic                ovf_reg;
   logic                in_ready_reg;

   logic                beat;
   logic [accSize-1:0]  add_result;
   logic                add_carry;
   logic [7:0]          count_next;
   logic [7:0]          len_first;

   assign beat       = in_valid && in_ready_reg;
   assign count_next = count_reg + 8'd1;
   assign len_first  = eff_len(len);

   mac_acc_adder #(
      .inSize  (inSize),
      .accSize (accSize)
   ) u_adder (
      .acc      (acc_reg),
      .addend   (in_data),
`ifdef MAC_ACCUMULATOR_SAT_EN
      .sat_hold (ovf_reg),
`endif
      .result   (add_result),
      .carry    (add_carry)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg     <= ST_IDLE;
         acc_reg       <= '0;
         count_reg     <= '0;
         len_reg       <= 8'd1;
         out_valid_reg <= 1'b0;
         ovf_reg       <= 1'b0;
         in_ready_reg  <= 1'b1;
      end else if (clear) begin
         // Abort wins over any beat or out_ready in the same cycle.
         state_reg     <= ST_IDLE;
         acc_reg       <= '0;
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         ovf_reg       <= 1'b0;
         in_ready_reg  <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (beat) begin
                  len_reg   <= len_first;
                  acc_reg   <= accSize'(in_data);
                  count_reg <= 8'd1;
                  ovf_reg   <= 1'b0;
                  if (len_first == 8'd1) begin
                     state_reg     <= ST_DONE;
                     out_valid_reg <= 1'b1;
                     in_ready_reg  <= 1'b0;
                  end else begin
                     state_reg <= ST_ACCUM;
                  end
               end
            end
            ST_ACCUM: begin
               if (beat) begin
                  acc_reg   <= add_result;
                  ovf_reg   <= ovf_reg | add_carry;
                  count_reg <= count_next;
                  if (count_next == len_reg) begin
                     state_reg     <= ST_DONE;
                     out_valid_reg <= 1'b1;
                     in_ready_reg  <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               // No new run may start in the hand-off cycle: in_ready is low here.
               if (out_ready) begin
                  state_reg     <= ST_IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign sum       = acc_reg;
   assign out_valid = out_valid_reg;
   assign ovf       = ovf_reg;
   assign in_ready  = in_ready_reg;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed scenarios plus randomized
// runs scored against an arithmetic model (default 21-bit and a 17-bit build).
module tb_mac_accumulator;

   localparam int DW   = 8;
   localparam int IW   = 2*DW + 1;
   localparam int AW   = 21;
   localparam int AW_S = 17;
`ifdef MAC_ACCUMULATOR_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic [IW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          clear = 1'b0;
   logic          out_ready = 1'b0;
   logic [7:0]    len = 8'd0;

   logic            in_ready, out_valid, ovf;
   logic [AW-1:0]   sum;
   logic            in_ready_s, out_valid_s, ovf_s;
   logic [AW_S-1:0] sum_s;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mac_accumulator #(.dataSize(DW), .accSize(AW)) u_main (
      .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .len(len), .clear(clear), .sum(sum),
      .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
   );

   mac_accumulator #(.dataSize(DW), .accSize(AW_S)) u_small (
      .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_s), .len(len), .clear(clear), .sum(sum_s),
      .out_valid(out_valid_s), .out_ready(out_ready), .ovf(ovf_s)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected result for a run whose true (unbounded) total is 'total'.
   function automatic logic [63:0] exp_sum(input logic [63:0] total, input int w);
      logic [63:0] lim;
      lim = 64'd1 << w;
      if (total < lim) return total;
      return SAT ? (lim - 64'd1) : (total % lim);
   endfunction

   function automatic logic [63:0] exp_ovf(input logic [63:0] total, input int w);
      return (total >= (64'd1 << w)) ? 64'd1 : 64'd0;
   endfunction

   // Present one sample for exactly one clock; called on a negedge.
   task automatic send(input logic [IW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = IW'($urandom);
   endtask

   task automatic take_result(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_ov_after_take"}, 64'(out_valid), 64'd0);
      check({tag, "_ir_after_take"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      int          l, eff, bub, dly;
      logic [63:0] total;
      logic [IW-1:0] d;

      // Reset state, observed while nrst is still low.
      #3;
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      $display("txn reset: sum=%0d out_valid=%0b in_ready=%0b", sum, out_valid, in_ready);

      // Directed 1: len=4, back-to-back samples.
      len = 8'd4;
      send(17'd10); send(17'd20); send(17'd30);
      check("d1_ov_early", 64'(out_valid), 64'd0);
      send(17'd40);
      check("d1_ov_cycle5", 64'(out_valid), 64'd1);
      check("d1_sum", 64'(sum), 64'd100);
      check("d1_ovf", 64'(ovf), 64'd0);
      $display("txn d1: len=4 sum=%0d ovf=%0b", sum, ovf);
      take_result("d1");

      // Directed 2: bubbles between samples, consumer stalls for 5 cycles.
      len = 8'd3;
      send(17'd1000); repeat (2) @(negedge clk);
      len = 8'd9;
      send(17'd2345); repeat (2) @(negedge clk);
      send(17'd77);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 17'h1ABCD;
         check("d2_hold_ov", 64'(out_valid), 64'd1);
         check("d2_hold_sum", 64'(sum), 64'd3422);
         check("d2_hold_ir", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      $display("txn d2: len=3 sum=%0d held 5 cycles", sum);
      take_result("d2");

      // Directed 3: carry out of a 17-bit accumulator.
      len = 8'd2;
      send(17'h1FFFF); send(17'h1FFFF);
      check("d3_small_sum", 64'(sum_s), exp_sum(64'h3FFFE, AW_S));
      check("d3_small_ovf", 64'(ovf_s), 64'd1);
      check("d3_main_sum", 64'(sum), 64'h3FFFE);
      check("d3_main_ovf", 64'(ovf), 64'd0);
      $display("txn d3: small sum=0x%0h ovf=%0b main sum=0x%0h", sum_s, ovf_s, sum);
      take_result("d3");

      // Directed 4: len=0 runs as len=1.
      len = 8'd0;
      send(17'd7);
      check("d4_ov", 64'(out_valid), 64'd1);
      check("d4_sum", 64'(sum), 64'd7);
      $display("txn d4: len=0 sum=%0d", sum);
      take_result("d4");

      // Directed 5: clear after 2 of 4 beats, colliding with a beat.
      len = 8'd4;
      send(17'd11); send(17'd12);
      clear = 1'b1; in_valid = 1'b1; in_data = 17'd99;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      check("d5_clr_sum", 64'(sum), 64'd0);
      check("d5_clr_ov", 64'(out_valid), 64'd0);
      check("d5_clr_ir", 64'(in_ready), 64'd1);
      repeat (3) @(negedge clk);
      check("d5_no_ov", 64'(out_valid), 64'd0);
      len = 8'd1;
      send(17'd5);
      check("d5_next_ov", 64'(out_valid), 64'd1);
      check("d5_next_sum", 64'(sum), 64'd5);
      $display("txn d5: aborted run, next sum=%0d", sum);
      take_result("d5");

      // Directed 6: asynchronous reset in the middle of a run.
      len = 8'd4;
      send(17'd300); send(17'd400);
      #2 nrst = 1'b0;
      #1;
      check("d6_async_sum", 64'(sum), 64'd0);
      check("d6_async_ov", 64'(out_valid), 64'd0);
      check("d6_async_ovf", 64'(ovf), 64'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("d6_ir", 64'(in_ready), 64'd1);
      len = 8'd2;
      send(17'd3); send(17'd4);
      check("d6_next_ov", 64'(out_valid), 64'd1);
      check("d6_next_sum", 64'(sum), 64'd7);
      $display("txn d6: reset mid-run, next sum=%0d", sum);
      take_result("d6");

      // Randomized runs scored against the arithmetic model.
      for (int r = 0; r < 30; r++) begin
         l     = int'($urandom_range(0, 20));
         eff   = (l == 0) ? 1 : l;
         total = 64'd0;
         len   = 8'(l);
         for (int k = 0; k < eff; k++) begin
            d = IW'($urandom);
            total = total + 64'(d);
            if (k == 1) len = 8'($urandom);
            send(d);
            if (k != eff - 1) begin
               check("rnd_ov_early", 64'(out_valid), 64'd0);
               bub = int'($urandom_range(0, 2));
               repeat (bub) @(negedge clk);
            end
         end
         check("rnd_ov", 64'(out_valid), 64'd1);
         check("rnd_sum", 64'(sum), exp_sum(total, AW));
         check("rnd_ovf", 64'(ovf), exp_ovf(total, AW));
         check("rnd_sum_s", 64'(sum_s), exp_sum(total, AW_S));
         check("rnd_ovf_s", 64'(ovf_s), exp_ovf(total, AW_S));
         $display("txn rnd%0d: len=%0d total=%0d sum=%0d ovf=%0b sum_s=%0d ovf_s=%0b",
                  r, l, total, sum, ovf, sum_s, ovf_s);
         dly = int'($urandom_range(0, 3));
         repeat (dly) @(negedge clk);
         check("rnd_hold_sum", 64'(sum), exp_sum(total, AW));
         take_result("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
